// File: rtl/pe_pkg.sv
// Shared types for the PE weight-load path.
package pe_pkg;

  typedef enum logic [1:0] {
    PE_LD_IDLE,
    PE_LD_LOAD,
    PE_LD_DONE
  } pe_ld_state_e;

endpackage

// File: rtl/binary_decoder.sv
// Binary-to-one-hot decoder with enable; all-zero output when disabled.
module binary_decoder #(
  parameter int ADDR_WIDTH = 3
) (
  input  logic [ADDR_WIDTH-1:0]      addr,
  input  logic                       en,
  output logic [(1<<ADDR_WIDTH)-1:0] dec
);

  always_comb begin
    // NOTE: default-assign every combinational output first so no path infers a latch.
    dec = '0;
    if (en) dec[addr] = 1'b1;
  end

endmodule

// File: rtl/pe_weight_load_ctrl.sv
// Streams a burst of weight words into consecutive PE slots starting at a base
// address, producing a registered one-hot write-enable and a done pulse.
module pe_weight_load_ctrl
  import pe_pkg::*;
#(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [ADDR_WIDTH-1:0]      base_addr,
  input  logic [ADDR_WIDTH:0]        num_words,
  input  logic                       abort,
  input  logic                       in_valid,
  input  logic [DATA_WIDTH-1:0]      in_data,
  output logic                       in_ready,
  output logic [(1<<ADDR_WIDTH)-1:0] wr_en,
  output logic [DATA_WIDTH-1:0]      wr_data,
  output logic                       busy,
  output logic                       done
);

  localparam int                  NSLOT   = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] NSLOT_W = (ADDR_WIDTH+1)'(NSLOT);
  localparam logic [ADDR_WIDTH:0] ONE_W   = (ADDR_WIDTH+1)'(1);

  pe_ld_state_e          state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH:0]   remaining;
  logic [ADDR_WIDTH:0]   start_count;
  logic [NSLOT-1:0]      dec;
  logic                  beat;

  // abort gates in_ready, so an aborted cycle can never produce a beat or a write.
  assign in_ready    = (state == PE_LD_LOAD) && !abort;
  assign beat        = in_valid && in_ready;
  assign busy        = (state != PE_LD_IDLE);
  assign start_count = (num_words > NSLOT_W) ? NSLOT_W : num_words;

  binary_decoder #(.ADDR_WIDTH(ADDR_WIDTH)) u_dec (
    .addr (addr),
    .en   (beat),
    .dec  (dec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= PE_LD_IDLE;
      addr      <= '0;
      remaining <= '0;
      wr_en     <= '0;
      wr_data   <= '0;
      done      <= 1'b0;
    end else begin
      // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
      wr_en <= dec;
      done  <= 1'b0;
      if (beat) wr_data <= in_data;

      unique case (state)
        PE_LD_IDLE: begin
          if (start) begin
            addr      <= base_addr;
            remaining <= start_count;
            if (start_count == '0) begin
              state <= PE_LD_DONE;
              done  <= 1'b1;
            end else begin
              state <= PE_LD_LOAD;
            end
          end
        end
        PE_LD_LOAD: begin
          if (abort) begin
            state <= PE_LD_IDLE;
          end else if (beat) begin
            addr      <= addr + 1'b1;
            remaining <= remaining - ONE_W;
            if (remaining == ONE_W) begin
              state <= PE_LD_DONE;
              done  <= 1'b1;
            end
          end
        end
        PE_LD_DONE: state <= PE_LD_IDLE;
        default:    state <= PE_LD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_weight_load_ctrl.sv
// Scoreboard bench for pe_weight_load_ctrl: a burst-level model queues expected
// slot writes; a negedge monitor pops and compares them against the DUT.
module tb_pe_weight_load_ctrl;

  localparam int AW    = 3;
  localparam int DW    = 8;
  localparam int NSLOT = 1 << AW;
  localparam int GUARD = 100;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   num_words = '0;
  logic          abort = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic [NSLOT-1:0] wr_en;
  logic [DW-1:0] wr_data;
  logic          busy;
  logic          done;

  pe_weight_load_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .num_words (num_words),
    .abort     (abort),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected slot write: which slot, which word, and the cycle it must appear in.
  typedef struct {
    int            slot;
    logic [DW-1:0] data;
    int            due;
  } wr_t;

  wr_t exp_q[$];
  int  cyc = 0;
  int  m_left = 0;      // words still to accept in the current burst
  int  m_addr = 0;      // next slot (unwrapped)
  bit  m_done_cyc = 0;  // this cycle is the burst's completion cycle

  logic [NSLOT-1:0] wr_or;
  int               wr_cnt;

  // Burst-level reference model, advanced once per rising edge.
  always @(posedge clk) begin
    if (rst_n) begin
      cyc++;
      if (abort && (m_left > 0 || m_done_cyc)) begin
        m_left     = 0;
        m_done_cyc = 0;
      end else if (m_left > 0) begin
        if (in_valid) begin
          exp_q.push_back('{m_addr % NSLOT, in_data, cyc});
          m_addr++;
          m_left--;
          m_done_cyc = (m_left == 0);
        end
      end else if (m_done_cyc) begin
        m_done_cyc = 0;
      end else if (start) begin
        m_addr     = int'(base_addr);
        m_left     = (int'(num_words) > NSLOT) ? NSLOT : int'(num_words);
        m_done_cyc = (m_left == 0);
      end
    end
  end

  // Monitor: compares DUT outputs mid-cycle against the model and scoreboard.
  always @(negedge clk) begin
    logic [NSLOT-1:0] exp_en;
    logic [DW-1:0]    exp_d;
    wr_t              w;
    if (rst_n) begin
      exp_en = '0;
      exp_d  = '0;
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        w      = exp_q.pop_front();
        exp_en = NSLOT'(1 << w.slot);
        exp_d  = w.data;
      end
      check("wr_en", 32'(wr_en), 32'(exp_en));
      if (exp_en != '0) check("wr_data", 32'(wr_data), 32'(exp_d));
      check("done", 32'(done), 32'(m_done_cyc));
      check("busy", 32'(busy), 32'(m_left > 0 || m_done_cyc));
      check("in_ready", 32'(in_ready), 32'(m_left > 0 && !abort));
      wr_or |= wr_en;
      if (wr_en != '0) wr_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n    = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("rst_wr_en", 32'(wr_en), 32'h0);
    check("rst_wr_data", 32'(wr_data), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h0);
    m_left     = 0;
    m_done_cyc = 0;
    m_addr     = 0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Idle cycles with noise on abort/in_valid, which must have no effect.
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      start    = 1'b0;
      abort    = 1'($urandom_range(0, 1));
      in_valid = 1'($urandom_range(0, 1));
      in_data  = DW'($urandom);
      step();
    end
    abort    = 1'b0;
    in_valid = 1'b0;
  endtask

  // mode: 0 back-to-back, 1 valid every other cycle, 2 random valid.
  // abort_beat: abort together with in_valid on that beat (0 = none).
  // reset_beat: async reset after that many beats have been written (0 = none).
  task automatic run_burst(input int base, input int num, input int mode,
                           input int abort_beat, input int reset_beat,
                           input logic [DW-1:0] data0);
    int            beats = 0;
    int            guard = 0;
    logic [DW-1:0] d = data0;
    bit            v;
    wr_or     = '0;
    wr_cnt    = 0;
    start     = 1'b1;
    base_addr = AW'(base);
    num_words = (AW+1)'(num);
    in_valid  = 1'b0;
    abort     = 1'b0;
    step();
    start = 1'b0;
    while ((m_left > 0 || m_done_cyc) && guard < GUARD) begin
      guard++;
      if (reset_beat > 0 && beats == reset_beat) begin
        if (exp_q.size() > 0) check("pre_reset_wr_en", 32'(wr_en), 32'(1 << exp_q[0].slot));
        apply_reset();
        break;
      end
      // Changes to start/base/num while busy must be ignored.
      start     = 1'($urandom_range(0, 1));
      base_addr = AW'($urandom);
      num_words = (AW+1)'($urandom);
      case (mode)
        0:       v = 1'b1;
        1:       v = (guard % 2 == 1);
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      abort    = (abort_beat > 0 && beats == abort_beat - 1 && v && m_left > 0);
      in_valid = v;
      in_data  = d;
      if (v && m_left > 0 && !abort) begin
        beats++;
        d++;
      end
      step();
    end
    check("burst_within_budget", 32'(guard < GUARD), 32'h1);
    start    = 1'b0;
    abort    = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    int base, num, mode, ab, cnt, exp_cnt;
    #1;
    apply_reset();
    idle_cycles(5);

    run_burst(2, 3, 0, 0, 0, 8'hA1);
    check("basic_cnt", 32'(wr_cnt), 32'd3);
    check("basic_slots", 32'(wr_or), 32'h1C);
    idle_cycles(2);

    run_burst(6, 4, 1, 0, 0, 8'h11);
    check("wrap_cnt", 32'(wr_cnt), 32'd4);
    check("wrap_slots", 32'(wr_or), 32'hC3);
    idle_cycles(2);

    run_burst(int'($urandom_range(0, NSLOT-1)), 9, 0, 0, 0, 8'h30);
    check("clamp_cnt", 32'(wr_cnt), 32'd8);
    check("clamp_slots", 32'(wr_or), 32'hFF);
    idle_cycles(2);

    run_burst(3, 0, 0, 0, 0, 8'h00);
    check("zero_cnt", 32'(wr_cnt), 32'd0);
    idle_cycles(2);

    run_burst(0, 5, 0, 3, 0, 8'h50);
    check("abort_cnt", 32'(wr_cnt), 32'd2);
    check("abort_slots", 32'(wr_or), 32'h03);
    idle_cycles(2);

    run_burst(4, 6, 0, 0, 2, 8'h70);
    idle_cycles(3);
    run_burst(0, 2, 0, 0, 0, 8'h55);
    check("post_reset_cnt", 32'(wr_cnt), 32'd2);
    check("post_reset_slots", 32'(wr_or), 32'h03);
    idle_cycles(2);

    for (int i = 0; i < 20; i++) begin
      base    = int'($urandom_range(0, NSLOT-1));
      num     = int'($urandom_range(0, 2*NSLOT-1));
      mode    = int'($urandom_range(0, 2));
      ab      = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, NSLOT)) : 0;
      cnt     = (num > NSLOT) ? NSLOT : num;
      exp_cnt = (ab > 0 && ab <= cnt) ? ab - 1 : cnt;
      run_burst(base, num, mode, ab, 0, DW'($urandom));
      check("rand_cnt", 32'(wr_cnt), 32'(exp_cnt));
      if (exp_cnt == NSLOT) check("rand_full_slots", 32'(wr_or), 32'hFF);
      idle_cycles(int'($urandom_range(0, 3)));
    end

    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
